// File: rtl/cr_tlvp_pkg.sv
// Shared definitions for the TLV mux/router: action encodings, header layout,
// parser states and the word/order-queue entry formats.
package cr_tlvp_pkg;

    localparam int TLVP_ACT_PASS = 0;
    localparam int TLVP_TYPE_LSB = 0;
    localparam int TLVP_DW       = 64;
    localparam int TLVP_SRC_W    = 3;

    // Drop is the code just above the last user channel.
    function automatic int TLVP_ACT_DROP(input int n_usr);
        return n_usr + 1;
    endfunction

    function automatic int tlvp_len_lsb(input int type_w);
        return TLVP_TYPE_LSB + type_w;
    endfunction

    typedef enum logic [1:0] {TLVP_HDR, TLVP_BODY, TLVP_DROP} tlvp_state_e;

    typedef struct packed {
        logic [TLVP_SRC_W-1:0] src;
    } tlvp_oq_ent_t;

    typedef struct packed {
        logic [TLVP_DW-1:0] tdata;
        logic               tlast;
        logic               eot;
    } tlvp_mr_word_t;

endpackage

// File: rtl/cr_tlvp_mr_fifo.sv
// Show-ahead FIFO with full/almost-full/empty; a write at full succeeds when
// a read happens in the same cycle.
module cr_tlvp_mr_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_VAL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full,
    output logic         afull
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_ok, rd_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign afull = ((CW'(DEPTH) - cnt_q) <= CW'(AFULL_VAL));
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign rdata = mem_q[rp_q];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (wr_ok) wp_d = ptr_inc(wp_q);
        if (rd_ok) rp_d = ptr_inc(rp_q);
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wp_q] <= wdata;
    end

endmodule

// File: rtl/cr_tlvp_mux_router.sv
// TLV parser that routes each TLV to a user channel, passthrough or drop, and
// re-merges user returns and passthrough traffic in original arrival order.
module cr_tlvp_mux_router
    import cr_tlvp_pkg::*;
#(
    parameter int DW           = 64,
    parameter int N_USR        = 2,
    parameter int N_TYPES      = 16,
    parameter int TYPE_W       = 8,
    parameter int LEN_W        = 16,
    parameter int PT_DEPTH     = 16,
    parameter int UF_DEPTH     = 16,
    parameter int OQ_DEPTH     = 16,
    parameter int UF_AFULL_VAL = 2,
    localparam int AW = $clog2(N_USR + 2),
    localparam int SW = $clog2(N_USR + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tlvp_ib_empty,
    input  logic [DW-1:0]         tlvp_ib_tdata,
    input  logic                  tlvp_ib_tlast,
    output logic                  tlvp_ib_rd,
    input  logic [N_TYPES*AW-1:0] tlv_parse_action,
    output logic [N_USR-1:0]      usr_ib_empty,
    input  logic [N_USR-1:0]      usr_ib_rd,
    output logic [N_USR*DW-1:0]   usr_ib_tdata,
    output logic [N_USR-1:0]      usr_ib_tlast,
    output logic [N_USR-1:0]      usr_ib_eot,
    input  logic [N_USR-1:0]      usr_ob_wr,
    input  logic [N_USR*DW-1:0]   usr_ob_tdata,
    input  logic [N_USR-1:0]      usr_ob_tlast,
    input  logic [N_USR-1:0]      usr_ob_eot,
    output logic [N_USR-1:0]      usr_ob_full,
    output logic [N_USR-1:0]      usr_ob_afull,
    input  logic                  tlvp_ob_rd,
    output logic                  tlvp_ob_empty,
    output logic [DW-1:0]         tlvp_ob_tdata,
    output logic                  tlvp_ob_tlast,
    output logic                  tlvp_error
);
    localparam int WW      = DW + 2;
    localparam int LEN_LSB = tlvp_len_lsb(TYPE_W);

    tlvp_state_e      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [SW-1:0]    dest_q, dest_d;
    logic             err_q, err_d;

    logic [TYPE_W-1:0] hdr_type;
    logic [LEN_W-1:0]  hdr_len, hdr_rem;
    logic [AW-1:0]     hdr_act;
    logic              hdr_drop;
    logic [SW-1:0]     hdr_dest, wr_dest, sel;
    logic              ib_rd, parse_wr, parse_eot, parse_err, oq_push;
    logic [N_USR:0]    dst_full, src_empty;
    logic [WW-1:0]     src_head [N_USR+1];
    logic [WW-1:0]     uin_head [N_USR];
    logic [WW-1:0]     head_word;
    logic [N_USR-1:0]  uin_afull, uout_full, uout_rd;
    logic              pt_afull, oq_full, oq_afull, oq_empty, oq_rd, pt_rd, ob_pop;
    tlvp_oq_ent_t      oq_wdata, oq_head;
    logic              unused_ok;

    always_comb begin
        hdr_type = tlvp_ib_tdata[TLVP_TYPE_LSB +: TYPE_W];
        hdr_len  = tlvp_ib_tdata[LEN_LSB +: LEN_W];
        hdr_act  = AW'(TLVP_ACT_PASS);
        for (int i = 0; i < N_TYPES; i++) begin
            if (hdr_type == TYPE_W'(i)) hdr_act = tlv_parse_action[i*AW +: AW];
        end
        hdr_drop = (hdr_act == AW'(TLVP_ACT_DROP(N_USR)));
        hdr_dest = (hdr_act >= AW'(1) && hdr_act <= AW'(N_USR)) ? SW'(hdr_act) : '0;
        // A zero length is handled as a single-word TLV.
        hdr_rem  = (hdr_len == '0) ? '0 : hdr_len - LEN_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dest_d    = dest_q;
        ib_rd     = 1'b0;
        parse_wr  = 1'b0;
        parse_eot = 1'b0;
        parse_err = 1'b0;
        oq_push   = 1'b0;
        wr_dest   = dest_q;
        case (state_q)
            TLVP_HDR: begin
                wr_dest = hdr_dest;
                if (!tlvp_ib_empty && (hdr_drop || (!dst_full[hdr_dest] && !oq_full))) begin
                    ib_rd     = 1'b1;
                    parse_wr  = !hdr_drop;
                    oq_push   = !hdr_drop;
                    parse_eot = (hdr_rem == '0) || tlvp_ib_tlast;
                    parse_err = (hdr_len == '0) ||
                                (tlvp_ib_tlast && (hdr_drop || hdr_rem != '0));
                    rem_d     = hdr_rem;
                    dest_d    = hdr_dest;
                    if (hdr_rem != '0 && !tlvp_ib_tlast)
                        state_d = hdr_drop ? TLVP_DROP : TLVP_BODY;
                end
            end
            TLVP_BODY: begin
                if (!tlvp_ib_empty && !dst_full[dest_q]) begin
                    ib_rd     = 1'b1;
                    parse_wr  = 1'b1;
                    parse_eot = (rem_q == LEN_W'(1)) || tlvp_ib_tlast;
                    parse_err = tlvp_ib_tlast && (rem_q != LEN_W'(1));
                    rem_d     = rem_q - LEN_W'(1);
                    if (parse_eot) state_d = TLVP_HDR;
                end
            end
            TLVP_DROP: begin
                if (!tlvp_ib_empty) begin
                    ib_rd     = 1'b1;
                    parse_err = tlvp_ib_tlast;
                    rem_d     = rem_q - LEN_W'(1);
                    if (tlvp_ib_tlast || rem_q == LEN_W'(1)) state_d = TLVP_HDR;
                end
            end
            default: state_d = TLVP_HDR;
        endcase
        err_d = parse_err || (|(usr_ob_wr & uout_full));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLVP_HDR;
            rem_q   <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
        end
    end

    assign tlvp_ib_rd   = ib_rd && rst_n;
    assign tlvp_error   = err_q;
    assign oq_wdata.src = TLVP_SRC_W'(hdr_dest);

    cr_tlvp_mr_fifo #(.W(WW), .DEPTH(PT_DEPTH), .AFULL_VAL(UF_AFULL_VAL)) u_pt (
        .clk(clk), .rst_n(rst_n),
        .wr(parse_wr && wr_dest == '0), .wdata({tlvp_ib_tdata, tlvp_ib_tlast, parse_eot}),
        .rd(pt_rd), .rdata(src_head[0]),
        .empty(src_empty[0]), .full(dst_full[0]), .afull(pt_afull)
    );

    cr_tlvp_mr_fifo #(.W($bits(tlvp_oq_ent_t)), .DEPTH(OQ_DEPTH), .AFULL_VAL(1)) u_oq (
        .clk(clk), .rst_n(rst_n),
        .wr(oq_push), .wdata(oq_wdata),
        .rd(oq_rd), .rdata(oq_head),
        .empty(oq_empty), .full(oq_full), .afull(oq_afull)
    );

    for (genvar k = 0; k < N_USR; k++) begin : g_usr
        cr_tlvp_mr_fifo #(.W(WW), .DEPTH(UF_DEPTH), .AFULL_VAL(UF_AFULL_VAL)) u_in (
            .clk(clk), .rst_n(rst_n),
            .wr(parse_wr && wr_dest == SW'(k + 1)),
            .wdata({tlvp_ib_tdata, tlvp_ib_tlast, parse_eot}),
            .rd(usr_ib_rd[k]), .rdata(uin_head[k]),
            .empty(usr_ib_empty[k]), .full(dst_full[k+1]), .afull(uin_afull[k])
        );
        // Returns into a full FIFO are discarded and flagged as errors.
        cr_tlvp_mr_fifo #(.W(WW), .DEPTH(UF_DEPTH), .AFULL_VAL(UF_AFULL_VAL)) u_out (
            .clk(clk), .rst_n(rst_n),
            .wr(usr_ob_wr[k] && !uout_full[k]),
            .wdata({usr_ob_tdata[k*DW +: DW], usr_ob_tlast[k], usr_ob_eot[k]}),
            .rd(uout_rd[k]), .rdata(src_head[k+1]),
            .empty(src_empty[k+1]), .full(uout_full[k]), .afull(usr_ob_afull[k])
        );
        assign usr_ib_tdata[k*DW +: DW] = uin_head[k][WW-1:2];
        assign usr_ib_tlast[k]          = uin_head[k][1];
        assign usr_ib_eot[k]            = uin_head[k][0];
        assign usr_ob_full[k]           = uout_full[k];
        assign uout_rd[k]               = ob_pop && (sel == SW'(k + 1));
    end

    // Merge: only the source named by the oldest outstanding TLV may drain.
    assign sel           = SW'(oq_head.src);
    assign head_word     = src_head[sel];
    assign tlvp_ob_empty = oq_empty || src_empty[sel];
    assign tlvp_ob_tdata = head_word[WW-1:2];
    assign tlvp_ob_tlast = head_word[1];
    assign ob_pop        = tlvp_ob_rd && !tlvp_ob_empty;
    assign pt_rd         = ob_pop && (sel == '0);
    assign oq_rd         = ob_pop && head_word[0];

    assign unused_ok = ^{pt_afull, oq_afull, uin_afull, oq_head};

endmodule

// File: doc/cr_tlvp_mux_router.md
Name: cr_tlvp_mux_router

Overview:
- Parametrised next-generation TLV parser/re-sequencer on the compression datapath.
- Splits an inbound word stream into TLVs and routes each by type to one of N_USR user channels, a passthrough buffer, or a drop sink.
- Re-merges user-returned and passthrough TLVs onto one outbound stream in original arrival order.
- Adds multi-channel routing, per-type drop, and ordered re-merge; the earlier single-user parser has none of these.

Parameters:
- DW, 64: data word width.
- N_USR, 2: number of user channels, 1..6.
- N_TYPES, 16: number of types with programmable action. Types >= N_TYPES pass through.
- TYPE_W, 8: header type field width, at tdata[TYPE_W-1:0].
- LEN_W, 16: header length field (words incl. header), at tdata[TYPE_W+LEN_W-1:TYPE_W].
- PT_DEPTH, 16: passthrough FIFO depth.
- UF_DEPTH, 16: per-channel user in/out FIFO depth.
- OQ_DEPTH, 16: order-queue depth (TLVs in flight).
- UF_AFULL_VAL, 2: usr_ob_afull threshold (free entries).
- Localparams: AW=$clog2(N_USR+2); SW=$clog2(N_USR+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- tlvp_ib_empty  in  1  inbound show-ahead FIFO empty.
- tlvp_ib_tdata  in  DW  inbound head word.
- tlvp_ib_tlast  in  1  inbound frame end.
- tlvp_ib_rd  out  1  inbound pop.
- tlv_parse_action  in  N_TYPES*AW  per-type action: 0=pass, k in 1..N_USR = user channel k-1, N_USR+1=drop.
- usr_ib_empty  out  N_USR  per-channel empty.
- usr_ib_rd  in  N_USR  per-channel pop.
- usr_ib_tdata  out  N_USR*DW  per-channel head word.
- usr_ib_tlast  out  N_USR  frame end.
- usr_ib_eot  out  N_USR  last word of TLV.
- usr_ob_wr  in  N_USR  user return write.
- usr_ob_tdata  in  N_USR*DW  returned word.
- usr_ob_tlast  in  N_USR  returned frame end.
- usr_ob_eot  in  N_USR  returned end of TLV.
- usr_ob_full  out  N_USR  return FIFO full.
- usr_ob_afull  out  N_USR  return FIFO almost full.
- tlvp_ob_rd  in  1  outbound pop.
- tlvp_ob_empty  out  1  outbound empty.
- tlvp_ob_tdata  out  DW  outbound word.
- tlvp_ob_tlast  out  1  outbound frame end.
- tlvp_error  out  1  one-cycle error pulse.

Behaviour:
- Reset:
  - All FIFOs cleared; parser in HDR.
  - tlvp_ib_rd=0, usr_ib_empty=all 1, usr_ob_full=0, usr_ob_afull=0, tlvp_ob_empty=1, tlvp_error=0.
  - Reset mid-TLV discards all buffered state; no partial output afterwards.
- Parser FSM HDR/BODY/DROP:
  - HDR: header decoded combinationally from tlvp_ib_tdata. act = tlv_parse_action[type] (pass if type>=N_TYPES). rem = len-1.
  - HDR, len==0: treated as 1, tlvp_error pulses.
  - HDR rd condition: !ib_empty, and for non-drop also !dest_full && !oq_full.
  - HDR on rd: non-drop pushes order queue {src} (src 0=pass, k=user k-1) and writes the word to dest with eot=(rem==0).
  - HDR next state: drop -> DROP, else BODY; if rem==0, stays in HDR.
  - BODY: rd when !ib_empty && !dest_full. Writes word with eot=(rem==1). Decrements rem. Returns to HDR after the eot word.
  - DROP: rd when !ib_empty. Discards words. Same rem counting.
- Inbound tlast before rem reaches the last word: word forced eot=1, TLV truncated, FSM -> HDR, tlvp_error pulses.
- Dropped word carrying tlast: word discarded, tlvp_error pulses.
- tlast is forwarded unchanged with each routed word.
- Latency: word read in cycle T is visible at the dest FIFO head in T+1. Passthrough inbound-to-tlvp_ob minimum is 1 cycle.
- Output merge:
  - sel = order-queue head.
  - tlvp_ob_empty = oq_empty | src_empty[sel]. tdata and tlast are muxed from src[sel] head.
  - tlvp_ob_rd pops src[sel]; if that word has eot=1, the order queue pops the same cycle.
  - tlvp_ob_rd while empty is ignored.
- Strict order: a TLV is never emitted before all earlier TLVs complete. A stalled user channel blocks output only.
- User return protocol:
  - usr_ob_wr when full: word dropped, tlvp_error pulses.
  - User must return exactly one eot-terminated TLV per TLV received, in order; a 0-word return is illegal.
- Simultaneous events:
  - Parser write and merge read on the same FIFO in one cycle are legal at full.
  - Order-queue push and pop in the same cycle are legal.

Decomposition:
- Shared package (cr_tlvp_pkg additions):
  - Action encodings TLVP_ACT_PASS and TLVP_ACT_DROP.
  - Header field offset constants.
  - Order-entry typedef tlvp_oq_ent_t {src}.
  - Word typedef tlvp_mr_word_t {tdata, tlast, eot}.
- One sub-module: cr_tlvp_mr_fifo, a show-ahead FIFO with full/afull/empty and a depth parameter, instantiated for PT, user in, user out and OQ.
- Parser FSM and merge mux stay in the top level.

Test Plan:
- N_USR=2, actions: type 3 -> 1, type 5 -> drop, others pass. Frame: hdr(t=1,len=2), w, hdr(t=3,len=3), w, w(tlast) -> user0 sees 3 words with eot on 3rd. The top-level bench models user0 as a loopback/echo: every word read from usr_ib is written to usr_ob with tdata, tlast and eot unchanged. tlvp_ob then emits 5 words in input order, tlast on the 5th, no error.
- hdr(t=5,len=4) + 3 words, then hdr(t=2,len=1,tlast) -> the dropped TLV produces no output; one passthrough word out with tlast=1.
- User0 delays its return 20 cycles while passthrough TLVs follow -> tlvp_ob_empty=1 until user0's eot is drained, then the passthrough words emerge in order.
- hdr len=0 -> processed as a 1-word TLV, tlvp_error=1 for exactly one cycle.
- hdr len=4 with tlast on word 2 -> 2 words out, last has eot/tlast, one error pulse, next word parsed as a header.
- Fill PT to 16 with tlvp_ob_rd=0 -> tlvp_ib_rd=0. Assert rst_n=0 mid-TLV -> all empty=1, tlvp_ob_empty=1. The next frame after reset parses correctly.
